// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the ALU writeback path
//   and the multi-cycle load writeback path. Loads have fixed priority. A
//   starvation counter forces the ALU through after STARVE_LIMIT refused
//   cycles. A 32-entry busy scoreboard tracks registers with an outstanding
//   load and stalls issue on RAW/WAW hazards against them.
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   iss_valid/rs1/rs2/rd/is_load      issuing instruction from decode
//   iss_stall                         decode must hold the instruction
//   alu_valid/rd/data, alu_ready      ALU writeback request / grant
//   ld_valid/rd/data, ld_ready        load writeback request / grant
//   reg_we, rd_src, rd                registered register-file write port
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  input  logic [4:0]  iss_rd,
  input  logic        iss_is_load,
  output logic        iss_stall,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        reg_we,
  output logic [4:0]  rd_src,
  output logic [31:0] rd
);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      busy;
  logic [31:0]      busy_nxt;
  logic             force_alu;
  logic             alu_grant;
  logic             ld_grant;
  logic             iss_accept;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;

  assign force_alu = (cnt >= CNT_W'(STARVE_LIMIT));
  assign alu_grant = alu_valid & (~ld_valid | force_alu);
  assign ld_grant  = ld_valid & ~alu_grant;
  assign alu_ready = alu_grant;
  assign ld_ready  = ld_grant;

  // Stall looks at pre-edge busy only: no same-cycle bypass of a clearing load.
  assign iss_stall  = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]);
  assign iss_accept = iss_valid & ~iss_stall;

  assign wr_addr = alu_grant ? alu_rd : ld_rd;
  assign wr_data = alu_grant ? alu_data : ld_data;

  // Clear first, then set: a new load issuing to the same register is younger
  // than the one completing, so the bit must stay set.
  always_comb begin
    busy_nxt = busy;
    if (ld_grant) begin
      busy_nxt[ld_rd] = 1'b0;
    end
    if (iss_accept && iss_is_load) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!alu_valid || alu_grant) begin
      cnt <= '0;
    end else if (!force_alu) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A granted write to x0 is consumed but never reaches the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we <= 1'b0;
      rd_src <= '0;
      rd     <= '0;
    end else if (alu_grant || ld_grant) begin
      reg_we <= (wr_addr != 5'd0);
      rd_src <= wr_addr;
      rd     <= wr_data;
    end else begin
      reg_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
  logic        iss_is_load = 1'b0;
  logic        iss_stall;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic        reg_we;
  logic [4:0]  rd_src;
  logic [31:0] rd;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t w;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_is_load(iss_is_load), .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .reg_we(reg_we), .rd_src(rd_src), .rd(rd)
  );

  task automatic idle_inputs();
    iss_valid = 0; iss_is_load = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    alu_valid = 0; ld_valid = 0;
  endtask

  task automatic next_edge();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs();
    #12 rst_n = 1;
    next_edge();
    n_total++; if (reg_we !== 1'b0) $display("FAIL reset_we got=%0b exp=0", reg_we); else n_pass++;
    n_total++; if (rd_src !== 5'd0) $display("FAIL reset_rd_src got=%0d exp=0", rd_src); else n_pass++;
    n_total++; if (rd !== 32'd0) $display("FAIL reset_rd got=%h exp=0", rd); else n_pass++;
    iss_valid = 1; iss_rs1 = 5'd1; iss_rs2 = 5'd2; iss_rd = 5'd3; alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h33;
    #1;
    n_total++; if (iss_stall !== 1'b0) $display("FAIL reset_stall got=%0b exp=0", iss_stall); else n_pass++;
    n_total++; if (alu_ready !== 1'b1) $display("FAIL reset_alu_ready got=%0b exp=1", alu_ready); else n_pass++;
    n_total++; if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready got=%0b exp=0", ld_ready); else n_pass++;
    // Build busy[8] and a pending reg_we, then reset mid-cycle.
    iss_is_load = 1; iss_rd = 5'd8; iss_rs1 = 0; iss_rs2 = 0;
    next_edge();
    idle_inputs();
    n_total++; if (dut.busy !== 32'h0000_0100) $display("FAIL pre_reset_busy got=%h exp=00000100", dut.busy); else n_pass++;
    n_total++; if (reg_we !== 1'b1) $display("FAIL pre_reset_we got=%0b exp=1", reg_we); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_total++; if (reg_we !== 1'b0) $display("FAIL async_reset_we got=%0b exp=0", reg_we); else n_pass++;
    n_total++; if (dut.busy !== 32'd0) $display("FAIL async_reset_busy got=%h exp=0", dut.busy); else n_pass++;
    n_total++; if (dut.cnt !== 4'd0) $display("FAIL async_reset_cnt got=%0d exp=0", dut.cnt); else n_pass++;
    iss_valid = 1; iss_rs1 = 5'd8; #1;
    n_total++; if (iss_stall !== 1'b0) $display("FAIL async_reset_stall got=%0b exp=0", iss_stall); else n_pass++;
    idle_inputs();
    @(negedge clk); rst_n = 1;
    next_edge();
  endtask

  task automatic test_alu_alone();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    exp_q.push_back('{addr: 5'd5, data: 32'hDEAD_BEEF});
    @(negedge clk);
    n_total++; if (alu_ready !== 1'b1) $display("FAIL alu_alone_ready got=%0b exp=1", alu_ready); else n_pass++;
    next_edge();
    alu_valid = 0;
    w = exp_q.pop_front();
    n_total++; if (reg_we !== 1'b1 || rd_src !== w.addr || rd !== w.data)
      $display("FAIL alu_alone_write got we=%0b a=%0d d=%h exp we=1 a=%0d d=%h", reg_we, rd_src, rd, w.addr, w.data);
    else n_pass++;
    next_edge();
    n_total++; if (reg_we !== 1'b0 || rd_src !== 5'd5 || rd !== 32'hDEAD_BEEF)
      $display("FAIL alu_alone_hold got we=%0b a=%0d d=%h exp we=0 a=5 d=deadbeef", reg_we, rd_src, rd);
    else n_pass++;
  endtask

  task automatic test_contention();
    bit exp_alu;
    alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hA1A1_0000;
    ld_valid = 1;
    for (int i = 0; i < 5; i++) begin
      ld_rd = 5'(11 + i); ld_data = 32'h100 + i;
      exp_alu = (i == 4);
      if (exp_alu) exp_q.push_back('{addr: alu_rd, data: alu_data});
      else         exp_q.push_back('{addr: ld_rd, data: ld_data});
      @(negedge clk);
      n_total++; if (alu_ready !== exp_alu || ld_ready !== !exp_alu)
        $display("FAIL contention_grant cyc=%0d got alu=%0b ld=%0b exp alu=%0b ld=%0b", i, alu_ready, ld_ready, exp_alu, !exp_alu);
      else n_pass++;
      next_edge();
      if (exp_alu) alu_valid = 0;
      w = exp_q.pop_front();
      n_total++; if (reg_we !== 1'b1 || rd_src !== w.addr || rd !== w.data)
        $display("FAIL contention_write cyc=%0d got we=%0b a=%0d d=%h exp a=%0d d=%h", i, reg_we, rd_src, rd, w.addr, w.data);
      else n_pass++;
      if (i == 3) begin
        n_total++; if (dut.cnt !== 4'd4) $display("FAIL contention_cnt_sat got=%0d exp=4", dut.cnt); else n_pass++;
      end
    end
    n_total++; if (dut.cnt !== 4'd0) $display("FAIL contention_cnt_clear got=%0d exp=0", dut.cnt); else n_pass++;
    ld_valid = 0;
    next_edge();
  endtask

  task automatic test_hazard();
    iss_valid = 1; iss_is_load = 1; iss_rd = 5'd7; iss_rs1 = 5'd1; iss_rs2 = 5'd2;
    @(negedge clk);
    n_total++; if (iss_stall !== 1'b0) $display("FAIL hazard_first_issue got=%0b exp=0", iss_stall); else n_pass++;
    next_edge();
    iss_is_load = 0; iss_rs1 = 5'd7; iss_rs2 = 5'd0; iss_rd = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++; if (iss_stall !== 1'b1) $display("FAIL hazard_stall cyc=%0d got=%0b exp=1", i, iss_stall); else n_pass++;
      next_edge();
    end
    ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h77;
    exp_q.push_back('{addr: 5'd7, data: 32'h77});
    @(negedge clk);
    n_total++; if (ld_ready !== 1'b1 || iss_stall !== 1'b1)
      $display("FAIL hazard_clear_cycle got ld_ready=%0b stall=%0b exp 1 1", ld_ready, iss_stall);
    else n_pass++;
    next_edge();
    ld_valid = 0;
    w = exp_q.pop_front();
    n_total++; if (reg_we !== 1'b1 || rd_src !== w.addr || rd !== w.data)
      $display("FAIL hazard_ld_write got we=%0b a=%0d d=%h exp a=%0d d=%h", reg_we, rd_src, rd, w.addr, w.data);
    else n_pass++;
    @(negedge clk);
    n_total++; if (iss_stall !== 1'b0) $display("FAIL hazard_release got=%0b exp=0", iss_stall); else n_pass++;
    iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; #1;
    n_total++; if (iss_stall !== 1'b0) $display("FAIL hazard_x0 got=%0b exp=0", iss_stall); else n_pass++;
    idle_inputs();
    next_edge();
  endtask

  task automatic test_write_x0();
    ld_valid = 1; ld_rd = 5'd0; ld_data = 32'h1234;
    @(negedge clk);
    n_total++; if (ld_ready !== 1'b1) $display("FAIL x0_ready got=%0b exp=1", ld_ready); else n_pass++;
    next_edge();
    ld_valid = 0;
    n_total++; if (reg_we !== 1'b0) $display("FAIL x0_we got=%0b exp=0", reg_we); else n_pass++;
    n_total++; if (dut.busy !== 32'd0) $display("FAIL x0_busy got=%h exp=0", dut.busy); else n_pass++;
    next_edge();
  endtask

  task automatic test_same_edge();
    ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h99;
    iss_valid = 1; iss_is_load = 1; iss_rd = 5'd9; iss_rs1 = 0; iss_rs2 = 0;
    exp_q.push_back('{addr: 5'd9, data: 32'h99});
    @(negedge clk);
    n_total++; if (ld_ready !== 1'b1 || iss_stall !== 1'b0)
      $display("FAIL same_edge_accept got ld_ready=%0b stall=%0b exp 1 0", ld_ready, iss_stall);
    else n_pass++;
    next_edge();
    idle_inputs();
    w = exp_q.pop_front();
    n_total++; if (reg_we !== 1'b1 || rd_src !== w.addr || rd !== w.data)
      $display("FAIL same_edge_write got we=%0b a=%0d d=%h exp a=%0d d=%h", reg_we, rd_src, rd, w.addr, w.data);
    else n_pass++;
    n_total++; if (dut.busy !== 32'h0000_0200) $display("FAIL same_edge_busy got=%h exp=00000200", dut.busy); else n_pass++;
    iss_valid = 1; iss_rs1 = 5'd9; iss_rd = 5'd4; #1;
    n_total++; if (iss_stall !== 1'b1) $display("FAIL same_edge_stall got=%0b exp=1", iss_stall); else n_pass++;
    ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h9A;
    exp_q.push_back('{addr: 5'd9, data: 32'h9A});
    next_edge();
    ld_valid = 0;
    w = exp_q.pop_front();
    n_total++; if (reg_we !== 1'b1 || rd_src !== w.addr || rd !== w.data)
      $display("FAIL same_edge_write2 got we=%0b a=%0d d=%h exp a=%0d d=%h", reg_we, rd_src, rd, w.addr, w.data);
    else n_pass++;
    #1;
    n_total++; if (iss_stall !== 1'b0) $display("FAIL same_edge_release got=%0b exp=0", iss_stall); else n_pass++;
    idle_inputs();
    next_edge();
  endtask

  initial begin
    test_reset();
    test_alu_alone();
    test_contention();
    test_hazard();
    test_write_x0();
    test_same_edge();
    n_total++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
